sys_time_gen: RTL and testbench

SYS_TIME_GEN -- requirements
Module: sys_time_gen

---
 rtl/sys_time_gen_pkg.sv | 15 +
 rtl/sync_edge_detect.sv | 28 ++
 rtl/sys_time_gen.sv | 105 ++++++++++
 tb/tb_sys_time_gen.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/sys_time_gen_pkg.sv
// Shared parameters and types for the system time generator.
package sys_time_gen_pkg;

  // Default number of CLK edges from SYNC0 capture to the SYS_TIME load edge.
  localparam int unsigned SYNC_LATENCY_DEF = 2;
  // Default allowed deviation of a SYNC0 interval from its nominal period, in ticks.
  localparam int unsigned SYNC_TOL_DEF     = 4;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StLocked
  } state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with history flop and a registered rising-edge pulse.
module sync_edge_detect (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge
);

  logic r_s0, r_s1, r_s2, r_edge;

  // Synchronize, keep one cycle of history, and register the rising-edge pulse.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s0   <= 1'b0;
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s0   <= i_async;
      r_s1   <= r_s0;
      r_s2   <= r_s1;
      r_edge <= r_s1 & ~r_s2;
    end
  end

  assign o_edge = r_edge;

endmodule

// File: rtl/sys_time_gen.sv
// Free-running 64-bit system time, loaded from a latched value on an armed SYNC0 edge,
// with sticky supervision of the SYNC0 interval.
module sys_time_gen
  import sys_time_gen_pkg::*;
#(
  parameter int unsigned SYNC_LATENCY = SYNC_LATENCY_DEF,
  parameter int unsigned SYNC_TOL     = SYNC_TOL_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_cat_sync0,
  input  logic        i_set,
  input  logic [63:0] i_sync_time,
  input  logic [31:0] i_sync_period,
  output logic [63:0] o_sys_time,
  output logic        o_sync_edge,
  output logic        o_locked,
  output logic        o_sync_err
);

  localparam logic [31:0] IntervalMax = 32'hFFFF_FFFF;

  state_e      r_state, w_state_next;
  logic [63:0] r_sys_time, r_latched;
  logic [31:0] r_interval;
  logic        r_locked, r_err;
  logic        w_edge, w_load, w_check, w_viol;
  logic [32:0] w_diff, w_abs;

  sync_edge_detect u_sync_edge_detect (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_cat_sync0),
    .o_edge  (w_edge)
  );

  // SET always wins over a coincident edge, so a load needs SET low.
  assign w_load  = (r_state == StArmed) & w_edge & ~i_set;
  // The locking edge is excluded since the state is still ARMED there.
  assign w_check = (r_state == StLocked) & w_edge;

  // |interval - period| in 33-bit unsigned arithmetic; a saturated counter always violates.
  assign w_diff = {1'b0, r_interval} - {1'b0, i_sync_period};
  assign w_abs  = w_diff[32] ? (~w_diff + 33'd1) : w_diff;
  assign w_viol = (r_interval == IntervalMax) | (w_abs > 33'(SYNC_TOL));

  // Next-state decode: SET re-arms from any state, an armed edge locks.
  always_comb begin
    w_state_next = r_state;
    if (i_set) begin
      w_state_next = StArmed;
    end else if (w_edge && (r_state == StArmed)) begin
      w_state_next = StLocked;
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // System time, latched load value and interval counter.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sys_time <= 64'd0;
      r_latched  <= 64'd0;
      r_interval <= 32'd0;
    end else begin
      r_sys_time <= w_load ? (r_latched + 64'(SYNC_LATENCY)) : (r_sys_time + 64'd1);
      if (i_set) begin
        r_latched <= i_sync_time;
      end
      if (w_edge) begin
        r_interval <= 32'd1;
      end else if (r_interval != IntervalMax) begin
        r_interval <= r_interval + 32'd1;
      end
    end
  end

  // Registered status: lock decode and sticky interval error.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_locked <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_locked <= (w_state_next == StLocked);
      if (i_set) begin
        r_err <= 1'b0;
      end else if (w_check && w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_sys_time  = r_sys_time;
  assign o_sync_edge = w_edge;
  assign o_locked    = r_locked;
  assign o_sync_err  = r_err;

endmodule

// File: tb/tb_sys_time_gen.sv
// Directed bench for sys_time_gen with a timestamp-based reference model checked every cycle.
module tb_sys_time_gen;

  localparam int unsigned LAT = 2;
  localparam int unsigned TOL = 4;
  localparam longint unsigned IV_MAX = 64'h0000_0000_FFFF_FFFF;
  localparam int unsigned PER = 2048;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cat = 1'b0;
  logic        set = 1'b0;
  logic [63:0] sync_time = 64'd0;
  logic [31:0] period = PER;
  logic [63:0] sys_time;
  logic        sync_edge, locked, sync_err;

  int n_vec = 0;
  int n_bad = 0;

  sys_time_gen #(
    .SYNC_LATENCY (LAT),
    .SYNC_TOL     (TOL)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_cat_sync0   (cat),
    .i_set         (set),
    .i_sync_time   (sync_time),
    .i_sync_period (period),
    .o_sys_time    (sys_time),
    .o_sync_edge   (sync_edge),
    .o_locked      (locked),
    .o_sync_err    (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pulse timing comes from input/reset level history; intervals from pulse timestamps.
  bit [3:0]        rst_h = 4'b1111;   // [0] = this edge, [1] = previous edge, ...
  bit [3:0]        in_h  = 4'b0000;
  bit              dp    = 1'b0;      // pulse visible before this edge
  bit              pe, s0_2, s0_3, det;
  int              mode  = 0;         // 0 idle, 1 armed, 2 locked
  logic [63:0]     m_time = 64'd0;
  logic [63:0]     m_latched = 64'd0;
  bit              m_err = 1'b0;
  bit              m_locked = 1'b0;
  longint unsigned n = 0;
  longint unsigned origin = 1;
  longint unsigned iv, d;
  bit              sat_arm = 1'b0;    // bench request: treat the next measured interval as saturated
  bit              sat_done = 1'b0;

  always @(posedge clk) begin
    rst_h = {rst_h[2:0], rst};
    in_h  = {in_h[2:0], cat};
    s0_2  = !rst_h[2] && in_h[2];
    s0_3  = !rst_h[3] && in_h[3];
    pe    = !rst_h[0] && !rst_h[1] && s0_2 && !(!rst_h[2] && s0_3);
    det   = dp;
    dp    = pe;
    if (rst) begin
      mode = 0; m_time = 64'd0; m_latched = 64'd0; m_err = 1'b0; origin = n + 1;
    end else begin
      iv = n - origin;
      if (iv > IV_MAX) iv = IV_MAX;
      if (det && sat_arm && !sat_done) begin
        iv = IV_MAX;
        sat_done = 1'b1;
      end
      if (set) begin
        m_latched = sync_time; mode = 1; m_err = 1'b0; m_time = m_time + 64'd1;
      end else if (det && mode == 1) begin
        mode = 2; m_time = m_latched + 64'(LAT);
      end else begin
        if (det && mode == 2) begin
          d = (iv > longint'(period)) ? iv - longint'(period) : longint'(period) - iv;
          if (iv == IV_MAX || d > TOL) m_err = 1'b1;
        end
        m_time = m_time + 64'd1;
      end
      if (det) origin = n;
    end
    m_locked = (mode == 2);
    n++;
    #1;
    chk("sys_time", sys_time, m_time);
    chk("sync_edge", {63'd0, sync_edge}, {63'd0, pe});
    chk("locked", {63'd0, locked}, {63'd0, m_locked});
    chk("sync_err", {63'd0, sync_err}, {63'd0, m_err});
  end

  // ---------------- stimulus ----------------
  // One SYNC0 rise, held 3 cycles; returns 1 ns after the edge following the pulse.
  task automatic rise_and_pass(input string name);
    @(negedge clk) cat = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk(name, {63'd0, sync_edge}, 64'd1);
    @(negedge clk) cat = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Rise now and wait so the next rise lands n_cyc cycles later (negedge aligned).
  task automatic gen_period(input int n_cyc);
    cat = 1'b1;
    repeat (3) @(negedge clk);
    cat = 1'b0;
    repeat (n_cyc - 3) @(negedge clk);
  endtask

  task automatic arm(input logic [63:0] t);
    @(negedge clk) begin set = 1'b1; sync_time = t; end
    @(negedge clk) set = 1'b0;
  endtask

  int good_iv [10] = '{2051, 2045, 2052, 2044, 2048, 2050, 2046, 2048, 2047, 2049};

  initial begin
    // Reset held 5 cycles, with a SYNC0 pulse entirely inside it.
    repeat (1) @(negedge clk);
    cat = 1'b1;
    repeat (2) @(negedge clk);
    cat = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_time0", sys_time, 64'd0);
    chk("rst_locked", {63'd0, locked}, 64'd0);
    chk("rst_edge", {63'd0, sync_edge}, 64'd0);
    @(posedge clk) #1 chk("rst_time1", sys_time, 64'd1);
    @(posedge clk) #1 chk("rst_time2", sys_time, 64'd2);
    repeat (4) @(posedge clk);
    #1 chk("rst_no_ghost", {63'd0, sync_edge}, 64'd0);

    // Lock on 1000; the lock rise also starts the nominal-period train.
    arm(64'd1000);
    rise_and_pass("lock_edge");
    chk("lock_time", sys_time, 64'd1002);
    chk("lock_locked", {63'd0, locked}, 64'd1);
    @(negedge clk);
    repeat (PER - 4) @(negedge clk);

    // Ten intervals within tolerance, including both +4 and -4.
    foreach (good_iv[i]) gen_period(good_iv[i]);
    gen_period(PER + 5);
    chk("nominal_no_err", {63'd0, sync_err}, 64'd0);

    // This rise ends the +5 interval.
    cat = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("drift_edge", {63'd0, sync_edge}, 64'd1);
    chk("drift_err_before", {63'd0, sync_err}, 64'd0);
    @(posedge clk) #1 chk("drift_err", {63'd0, sync_err}, 64'd1);
    @(negedge clk) cat = 1'b0;
    repeat (PER - 4) @(negedge clk);
    gen_period(PER);
    gen_period(PER);
    chk("drift_sticky", {63'd0, sync_err}, 64'd1);

    // SET clears the error and re-arms.
    arm(64'd5000);
    @(posedge clk) #1 chk("set_clears_err", {63'd0, sync_err}, 64'd0);
    chk("set_unlocks", {63'd0, locked}, 64'd0);

    // Collision: SET in the same cycle as the registered edge.
    @(negedge clk) cat = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("coll_edge", {63'd0, sync_edge}, 64'd1);
    @(negedge clk) begin set = 1'b1; sync_time = 64'd7000; cat = 1'b0; end
    @(posedge clk) #1 chk("coll_no_lock", {63'd0, locked}, 64'd0);
    @(negedge clk) set = 1'b0;
    repeat (6) @(negedge clk);
    rise_and_pass("coll_relock_edge");
    chk("coll_time", sys_time, 64'd7002);
    chk("coll_locked", {63'd0, locked}, 64'd1);

    // Wrap through 2^64.
    arm(64'hFFFF_FFFF_FFFF_FFFD);
    rise_and_pass("wrap_edge");
    chk("wrap_max", sys_time, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk) #1 chk("wrap_zero", sys_time, 64'd0);

    // Saturated interval counter always flags an error.
    repeat (10) @(negedge clk);
    force dut.r_interval = 32'hFFFF_FFFF;
    sat_arm = 1'b1;
    rise_and_pass("sat_edge");
    chk("sat_err", {63'd0, sync_err}, 64'd1);
    @(negedge clk) release dut.r_interval;

    // Reset mid-operation: no load, and the first edge afterwards is not evaluated.
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rise_and_pass("post_rst_edge");
    @(posedge clk) #1 chk("post_rst_err", {63'd0, sync_err}, 64'd0);
    chk("post_rst_locked", {63'd0, locked}, 64'd0);
    repeat (5) @(posedge clk);

    #2 $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
